// File: rtl/sec_bcd_timer_pkg.sv
// Shared constants and types for the mm:ss (optionally hh:mm:ss) BCD timer.
package sec_bcd_timer_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;
    localparam int HR_MAX       = 23;

    typedef logic [BCD_W-1:0] bcd_t;

    // True when a tens/ones digit pair spells the decimal value val.
    function automatic logic bcd_eq(input bcd_t tens, input bcd_t ones, input int val);
        return (tens == bcd_t'(val / 10)) && (ones == bcd_t'(val % 10));
    endfunction

endpackage

// File: rtl/sec_bcd_timer_bcd_digit.sv
// One BCD digit: counts 0..MAX on inc, flags carry when it rolls over.
// Any value above MAX (upset) is forced to 0 on the next increment.
module bcd_digit
    import sec_bcd_timer_pkg::*;
#(
    parameter int MAX = DIGIT_MAX
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    assign carry = inc & (q == bcd_t'(MAX));

    // Digit register: clear wins over increment; roll over at or past MAX.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc)
            q <= (q >= bcd_t'(MAX)) ? '0 : q + 1'b1;
    end

endmodule

// File: rtl/sec_bcd_timer.sv
// BCD stopwatch driven by the 1 Hz sec_clk square wave.
// Optional macro HOURS_EN adds hr_tens:hr_ones (00..23) and fixes the minute
// limit at 59; otherwise the count wraps after MIN_LIMIT:59.
module sec_bcd_timer
    import sec_bcd_timer_pkg::*;
#(
    parameter int MIN_LIMIT = 59
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic sec_clk,
    input  logic run_en,
    input  logic clr,
    output bcd_t sec_ones,
    output bcd_t sec_tens,
    output bcd_t min_ones,
    output bcd_t min_tens,
    output logic sec_tick,
    output logic wrap
`ifdef HOURS_EN
    ,
    output bcd_t hr_ones,
    output bcd_t hr_tens
`endif
);

`ifdef HOURS_EN
    localparam int LIMIT        = 59;
    localparam int MIN_TENS_MAX = SEC_TENS_MAX;
`else
    localparam int LIMIT        = MIN_LIMIT;
    localparam int MIN_TENS_MAX = DIGIT_MAX;
`endif

    logic sec_clk_d;
    logic rise;
    logic adv;
    logic at_limit;
    logic wrap_now;
    logic top_carry;
    logic digit_clr;
    logic c_so, c_st, c_mo, c_mt;

    assign rise = sec_clk & ~sec_clk_d;
    assign adv  = rise & run_en & ~clr;

`ifdef HOURS_EN
    logic c_ho, c_ht;
    assign at_limit  = bcd_eq(sec_tens, sec_ones, 59) & bcd_eq(min_tens, min_ones, LIMIT)
                     & bcd_eq(hr_tens, hr_ones, HR_MAX);
    assign top_carry = c_ht;
`else
    assign at_limit  = bcd_eq(sec_tens, sec_ones, 59) & bcd_eq(min_tens, min_ones, LIMIT);
    assign top_carry = c_mt;
`endif

    assign wrap_now = adv & at_limit;
    // Carry out of the most significant digit only arises from out-of-range
    // states; treat it as a rollover so every digit lands on zero together.
    assign digit_clr = clr | wrap_now | top_carry;

    // Edge detector samples continuously so re-enabling never fakes a tick.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst)
            sec_clk_d <= 1'b0;
        else
            sec_clk_d <= sec_clk;
    end

    // Pulse outputs line up with the cycle the digits change.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            sec_tick <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            sec_tick <= adv;
            wrap     <= wrap_now;
        end
    end

    bcd_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk_50M(clk_50M), .rst(rst), .clr(digit_clr), .inc(adv),
        .q(sec_ones), .carry(c_so)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk_50M(clk_50M), .rst(rst), .clr(digit_clr), .inc(c_so),
        .q(sec_tens), .carry(c_st)
    );

    bcd_digit #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk_50M(clk_50M), .rst(rst), .clr(digit_clr), .inc(c_st),
        .q(min_ones), .carry(c_mo)
    );

    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk_50M(clk_50M), .rst(rst), .clr(digit_clr), .inc(c_mo),
        .q(min_tens), .carry(c_mt)
    );

`ifdef HOURS_EN
    bcd_digit #(.MAX(DIGIT_MAX)) u_hr_ones (
        .clk_50M(clk_50M), .rst(rst), .clr(digit_clr), .inc(c_mt),
        .q(hr_ones), .carry(c_ho)
    );

    bcd_digit #(.MAX(HR_MAX / 10)) u_hr_tens (
        .clk_50M(clk_50M), .rst(rst), .clr(digit_clr), .inc(c_ho),
        .q(hr_tens), .carry(c_ht)
    );
`endif

endmodule
